plic_gateway_array: RTL and testbench

- Source-side front end of the PLIC interrupt path.
- Turns raw interrupt lines into the pending-masked priority/identifier arrays consumed by the find-max comparator tree.
- Handles the claim/complete handshake coming back from the target once the tree's winner is serviced.
- One gateway per source, instantiated in a generate loop; IDs are 1..NUM_SOURCES, and ID 0 means "no interrupt".

---
 rtl/plic_pkg.sv | 20 ++
 rtl/plic_gateway.sv | 98 +++++++++
 rtl/plic_gateway_array.sv | 56 +++++
 tb/tb_plic_gateway_array.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : plic_pkg
//  Brief    : Shared types and constants for the PLIC gateway array.
//  Revision : 1.0 - initial release
// ============================================================================
package plic_pkg;

  // Per-source gateway state.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } gw_state_e;

  // ID 0 is reserved to mean "no interrupt"; real sources are 1..N.
  localparam int unsigned NO_INTERRUPT_ID = 0;

endpackage
`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
//  Module   : plic_gateway
//  Brief    : One interrupt source gateway: level/edge capture, saturating
//             edge counter, claim/complete handshake keyed on its own ID.
//  Revision : 1.0 - initial release
// ============================================================================
module plic_gateway
  import plic_pkg::*;
#(
  parameter int unsigned               ID_BITWIDTH    = 3,
  parameter int unsigned               EDGE_CNT_WIDTH = 2,
  parameter logic [ID_BITWIDTH-1:0]    OWN_ID         = 1
) (
  input  logic                   ck,
  input  logic                   rst_n,
  input  logic                   irq_i,
  input  logic                   edge_sel_i,
  input  logic                   claim_valid_i,
  input  logic [ID_BITWIDTH-1:0] claim_id_i,
  input  logic                   complete_valid_i,
  input  logic [ID_BITWIDTH-1:0] complete_id_i,
  output logic                   pending_o,
  output logic                   in_service_o
);

  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [ID_BITWIDTH-1:0]    NONE_ID  = ID_BITWIDTH'(NO_INTERRUPT_ID);

  gw_state_e                 state_q, state_d;
  logic [EDGE_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      irq_q;
  logic                      pending_q, in_service_q;

  logic w_rise;
  logic w_claim_hit;
  logic w_complete_hit;

  // An edge is only meaningful in edge mode; level mode never touches the counter.
  assign w_rise         = edge_sel_i & irq_i & ~irq_q;
  // ID 0 can never match a real gateway, and IDs above the array size have no owner.
  assign w_claim_hit    = claim_valid_i    && (claim_id_i    == OWN_ID) && (claim_id_i    != NONE_ID);
  assign w_complete_hit = complete_valid_i && (complete_id_i == OWN_ID) && (complete_id_i != NONE_ID);

  // Next state and next edge count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (edge_sel_i) begin
          if (w_rise) begin
            state_d = PENDING;                 // fresh edge: banked edges stay banked
          end else if (cnt_q != CNT_ZERO) begin
            state_d = PENDING;                 // replay one banked edge
            cnt_d   = cnt_q - 1'b1;
          end
        end else if (irq_i) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (w_claim_hit) state_d = IN_SERVICE; // claim wins over a same-cycle complete
      end
      IN_SERVICE: begin
        if (w_complete_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Edges arriving while busy are banked, saturating at the counter maximum.
    if (w_rise && (state_q != IDLE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Gateway FSM, edge counter, irq history and registered status flags.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      irq_q        <= 1'b0;
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      irq_q        <= irq_i;
      pending_q    <= (state_d == PENDING);
      in_service_q <= (state_d == IN_SERVICE);
    end
  end

  assign pending_o    = pending_q;
  assign in_service_o = in_service_q;

endmodule
`default_nettype wire

// File: rtl/plic_gateway_array.sv
`default_nettype none
// ============================================================================
//  Module   : plic_gateway_array
//  Brief    : Array of per-source gateways feeding the find-max tree with
//             pending-masked priorities and constant source identifiers.
//  Revision : 1.0 - initial release
// ============================================================================
module plic_gateway_array
  import plic_pkg::*;
#(
  parameter int unsigned NUM_SOURCES       = 3,
  parameter int unsigned ID_BITWIDTH       = 3,
  parameter int unsigned PRIORITY_BITWIDTH = 4,
  parameter int unsigned EDGE_CNT_WIDTH    = 2
) (
  input  logic                         ck,
  input  logic                         rst_n,
  input  logic [NUM_SOURCES-1:0]       irq_sources_i,
  input  logic [NUM_SOURCES-1:0]       edge_sel_i,
  input  logic [PRIORITY_BITWIDTH-1:0] priorities_cfg_i [NUM_SOURCES],
  input  logic                         claim_valid_i,
  input  logic [ID_BITWIDTH-1:0]       claim_id_i,
  input  logic                         complete_valid_i,
  input  logic [ID_BITWIDTH-1:0]       complete_id_i,
  output logic [PRIORITY_BITWIDTH-1:0] priorities_o     [NUM_SOURCES],
  output logic [ID_BITWIDTH-1:0]       identifiers_o    [NUM_SOURCES],
  output logic [NUM_SOURCES-1:0]       pending_o,
  output logic [NUM_SOURCES-1:0]       in_service_o
);

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_gateway
    plic_gateway #(
      .ID_BITWIDTH    (ID_BITWIDTH),
      .EDGE_CNT_WIDTH (EDGE_CNT_WIDTH),
      .OWN_ID         (ID_BITWIDTH'(i + 1))
    ) u_gateway (
      .ck               (ck),
      .rst_n            (rst_n),
      .irq_i            (irq_sources_i[i]),
      .edge_sel_i       (edge_sel_i[i]),
      .claim_valid_i    (claim_valid_i),
      .claim_id_i       (claim_id_i),
      .complete_valid_i (complete_valid_i),
      .complete_id_i    (complete_id_i),
      .pending_o        (pending_o[i]),
      .in_service_o     (in_service_o[i])
    );

    // Identifiers are fixed wiring; a non-pending source presents priority 0
    // so it can never win the find-max tree against a real request.
    assign identifiers_o[i] = ID_BITWIDTH'(i + 1);
    assign priorities_o[i]  = pending_o[i] ? priorities_cfg_i[i] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_plic_gateway_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plic_gateway_array
//  Brief    : Directed-vector scoreboard bench for plic_gateway_array.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_plic_gateway_array;

  logic       ck = 1'b0;
  logic       rst_n;
  logic [2:0] irq;
  logic [2:0] edge_sel;
  logic [3:0] cfg [3];
  logic       cv;
  logic [2:0] cid;
  logic       pv;
  logic [2:0] pid;
  logic [3:0] prio_o [3];
  logic [2:0] ids_o  [3];
  logic [2:0] pend_o;
  logic [2:0] is_o;

  plic_gateway_array #(
    .NUM_SOURCES       (3),
    .ID_BITWIDTH       (3),
    .PRIORITY_BITWIDTH (4),
    .EDGE_CNT_WIDTH    (2)
  ) dut (
    .ck               (ck),
    .rst_n            (rst_n),
    .irq_sources_i    (irq),
    .edge_sel_i       (edge_sel),
    .priorities_cfg_i (cfg),
    .claim_valid_i    (cv),
    .claim_id_i       (cid),
    .complete_valid_i (pv),
    .complete_id_i    (pid),
    .priorities_o     (prio_o),
    .identifiers_o    (ids_o),
    .pending_o        (pend_o),
    .in_service_o     (is_o)
  );

  always #5 ck = ~ck;

  int edge_cnt = 0;
  always @(posedge ck) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         tgt;
    logic [2:0] pend;
    logic [2:0] isv;
    logic [11:0] prio;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, req);
    end
  endtask

  function automatic logic [11:0] exp_prio(input logic [2:0] p);
    return {p[2] ? cfg[2] : 4'd0, p[1] ? cfg[1] : 4'd0, p[0] ? cfg[0] : 4'd0};
  endfunction

  // Drive one cycle of stimulus at the falling edge; the expectation is for
  // the state seen after the following rising edge.
  task automatic cyc(input string tag, input logic [2:0] i_irq,
                     input logic i_cv, input logic [2:0] i_cid,
                     input logic i_pv, input logic [2:0] i_pid,
                     input logic [2:0] e_pend, input logic [2:0] e_is);
    exp_t e;
    @(negedge ck);
    irq = i_irq; cv = i_cv; cid = i_cid; pv = i_pv; pid = i_pid;
    e.tgt  = edge_cnt + 1;
    e.pend = e_pend;
    e.isv  = e_is;
    e.prio = exp_prio(e_pend);
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Change configuration only after the previous expectation has been sampled.
  task automatic set_cfg(input int idx, input logic [3:0] val);
    @(posedge ck);
    #2;
    cfg[idx] = val;
  endtask

  // Monitor: after each rising edge, compare every expectation due now.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge ck);
      #1;
      while (sb.size() > 0 && sb[0].tgt <= edge_cnt) begin
        e = sb.pop_front();
        if (e.tgt != edge_cnt) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s stale: sampled at edge %0d, expected edge %0d", e.tag, edge_cnt, e.tgt);
        end else begin
          check({e.tag, " pending"},    32'(pend_o), 32'(e.pend));
          check({e.tag, " in_service"}, 32'(is_o),   32'(e.isv));
          check({e.tag, " priorities"}, 32'({prio_o[2], prio_o[1], prio_o[0]}), 32'(e.prio));
        end
      end
    end
  end

  initial begin : stim
    int best;
    int win;
    rst_n    = 1'b0;
    irq      = 3'b000;
    edge_sel = 3'b001;
    cfg      = '{4'd4, 4'd5, 4'd7};
    cv = 1'b0; cid = 3'd0; pv = 1'b0; pid = 3'd0;

    // Reset state
    repeat (2) @(posedge ck);
    #1;
    check("reset pending",    32'(pend_o), 32'h0);
    check("reset in_service", 32'(is_o),   32'h0);
    check("reset priorities", 32'({prio_o[2], prio_o[1], prio_o[0]}), 32'h0);
    check("reset identifiers", 32'({ids_o[2], ids_o[1], ids_o[0]}), 32'({3'd3, 3'd2, 3'd1}));
    @(negedge ck);
    rst_n = 1'b1;

    // Level source 2, priority 5: pend, claim, complete with line high, re-arm
    cyc("A1 lvl pend",       3'b010, 0, 3'd0, 0, 3'd0, 3'b010, 3'b000);
    cyc("A2 claim2",         3'b010, 1, 3'd2, 0, 3'd0, 3'b000, 3'b010);
    cyc("A3 hold",           3'b010, 0, 3'd0, 0, 3'd0, 3'b000, 3'b010);
    cyc("A4 complete2",      3'b010, 0, 3'd0, 1, 3'd2, 3'b000, 3'b000);
    cyc("A5 rearm",          3'b010, 0, 3'd0, 0, 3'd0, 3'b010, 3'b000);
    cyc("A6 claim2",         3'b000, 1, 3'd2, 0, 3'd0, 3'b000, 3'b010);
    cyc("A7 complete2",      3'b000, 0, 3'd0, 1, 3'd2, 3'b000, 3'b000);
    cyc("A8 quiet",          3'b000, 0, 3'd0, 0, 3'd0, 3'b000, 3'b000);

    // Edge source 1: 4 pulses while in service saturate the counter at 3
    cyc("B1 edge pend",      3'b001, 0, 3'd0, 0, 3'd0, 3'b001, 3'b000);
    cyc("B2 claim1",         3'b000, 1, 3'd1, 0, 3'd0, 3'b000, 3'b001);
    for (int k = 0; k < 4; k++) begin
      cyc("B pulse hi",      3'b001, 0, 3'd0, 0, 3'd0, 3'b000, 3'b001);
      cyc("B pulse lo",      3'b000, 0, 3'd0, 0, 3'd0, 3'b000, 3'b001);
    end
    cyc("B complete1",       3'b000, 0, 3'd0, 1, 3'd1, 3'b000, 3'b000);
    for (int r = 0; r < 3; r++) begin
      cyc("B replay pend",   3'b000, 0, 3'd0, 0, 3'd0, 3'b001, 3'b000);
      cyc("B replay claim",  3'b000, 1, 3'd1, 0, 3'd0, 3'b000, 3'b001);
      cyc("B replay done",   3'b000, 0, 3'd0, 1, 3'd1, 3'b000, 3'b000);
    end
    cyc("B no 4th",          3'b000, 0, 3'd0, 0, 3'd0, 3'b000, 3'b000);
    cyc("B still none",      3'b000, 0, 3'd0, 0, 3'd0, 3'b000, 3'b000);

    // Invalid IDs and complete-in-PENDING are ignored
    cyc("C1 lvl3 pend",      3'b100, 0, 3'd0, 0, 3'd0, 3'b100, 3'b000);
    cyc("C2 claim id0",      3'b100, 1, 3'd0, 0, 3'd0, 3'b100, 3'b000);
    cyc("C3 claim id7",      3'b100, 1, 3'd7, 0, 3'd0, 3'b100, 3'b000);
    cyc("C4 claim id4",      3'b100, 1, 3'd4, 0, 3'd0, 3'b100, 3'b000);
    cyc("C5 complete pend",  3'b100, 0, 3'd0, 1, 3'd3, 3'b100, 3'b000);

    // Simultaneous claim + complete on ID 3
    cyc("D1 both pend",      3'b100, 1, 3'd3, 1, 3'd3, 3'b000, 3'b100);
    cyc("D2 both insvc",     3'b100, 1, 3'd3, 1, 3'd3, 3'b000, 3'b000);
    cyc("D3 rearm",          3'b100, 0, 3'd0, 0, 3'd0, 3'b100, 3'b000);
    cyc("D4 claim3",         3'b000, 1, 3'd3, 0, 3'd0, 3'b000, 3'b100);
    cyc("D5 complete3",      3'b000, 0, 3'd0, 1, 3'd3, 3'b000, 3'b000);

    // Build src1 PENDING with two banked edges and src2 IN_SERVICE
    cyc("E1 lvl2 pend",      3'b010, 0, 3'd0, 0, 3'd0, 3'b010, 3'b000);
    cyc("E2 claim2",         3'b010, 1, 3'd2, 0, 3'd0, 3'b000, 3'b010);
    cyc("E3 edge1",          3'b011, 0, 3'd0, 0, 3'd0, 3'b001, 3'b010);
    cyc("E4 lo",             3'b010, 0, 3'd0, 0, 3'd0, 3'b001, 3'b010);
    cyc("E5 edge cnt1",      3'b011, 0, 3'd0, 0, 3'd0, 3'b001, 3'b010);
    cyc("E6 lo",             3'b010, 0, 3'd0, 0, 3'd0, 3'b001, 3'b010);
    cyc("E7 edge cnt2",      3'b011, 0, 3'd0, 0, 3'd0, 3'b001, 3'b010);

    // Asynchronous reset mid-cycle clears everything immediately
    @(posedge ck);
    #3;
    irq = 3'b001;
    cv  = 1'b0;
    pv  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async rst pending",    32'(pend_o), 32'h0);
    check("async rst in_service", 32'(is_o),   32'h0);
    check("async rst priorities", 32'({prio_o[2], prio_o[1], prio_o[0]}), 32'h0);
    @(negedge ck);
    rst_n = 1'b1;
    // Line still high at release counts as exactly one edge; banked edges are gone
    cyc("R1 one edge",       3'b001, 0, 3'd0, 0, 3'd0, 3'b001, 3'b000);
    cyc("R2 claim1",         3'b001, 1, 3'd1, 0, 3'd0, 3'b000, 3'b001);
    cyc("R3 complete1",      3'b001, 0, 3'd0, 1, 3'd1, 3'b000, 3'b000);
    cyc("R4 no replay",      3'b001, 0, 3'd0, 0, 3'd0, 3'b000, 3'b000);
    cyc("R5 no replay",      3'b001, 0, 3'd0, 0, 3'd0, 3'b000, 3'b000);

    // All pending with priorities 4, 7, 7
    cyc("F1 drop",           3'b000, 0, 3'd0, 0, 3'd0, 3'b000, 3'b000);
    set_cfg(1, 4'd7);
    cyc("F2 all pend",       3'b111, 0, 3'd0, 0, 3'd0, 3'b111, 3'b000);
    @(posedge ck);
    #2;
    best = 0;
    win  = 0;
    for (int i = 0; i < 3; i++) begin
      if (int'(prio_o[i]) > best) begin
        best = int'(prio_o[i]);
        win  = int'(ids_o[i]);
      end
    end
    check("find-max winner", 32'(win), 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("identifier", 32'(ids_o[i]), 32'(i + 1));
    end
    cfg[2] = 4'd0;
    // Priority 0 while pending: output 0, still claimable
    cyc("F3 prio0 pend",     3'b111, 0, 3'd0, 0, 3'd0, 3'b111, 3'b000);
    cyc("F4 claim3",         3'b111, 1, 3'd3, 0, 3'd0, 3'b011, 3'b100);
    cyc("F5 complete3",      3'b000, 0, 3'd0, 1, 3'd3, 3'b011, 3'b000);
    cyc("F6 idle strobes",   3'b000, 0, 3'd0, 0, 3'd0, 3'b011, 3'b000);

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge ck);
    #3;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
